lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Owns the 16x2 character LCD write port: the 8-bit data, RS, RW and EN pins.
- After reset it waits out LCD power-up, then issues the fixed init command sequence.
- After init it shares the port between NREQ requesters using round-robin arbitration.
- Each granted command or character write gets the required setup, enable-pulse, hold and execution-wait timing before the requester is acknowledged.

Parameters:
- NREQ, 2, number of requesters (1..8).
- T_SU, 4, cycles that RS/DATA are stable before EN rises.
- T_EN, 16, cycles EN is held high.
- T_HLD, 4, cycles RS/DATA are held after EN falls.
- T_CMD, 2000, execution wait after a normal write (40 us at 50 MHz).
- T_CLR, 82000, execution wait after a clear (0x01) or home (0x02/0x03) command (1.64 ms).
- T_PWR, 750000, power-up wait after reset (15 ms).

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- req  in  NREQ  per-requester write request, level.
- req_rs  in  NREQ  RS for each requester: 0 = command, 1 = data.
- req_data  in  8*NREQ  byte for each requester; requester i uses bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse when requester i's write has fully completed.
- gnt  out  NREQ  one-hot; high while requester i's write is in flight.
- ready  out  1  init sequence complete.
- busy  out  1  state is not IDLE.
- LCD_DATA  out  8  LCD data bus; write-only, always driven.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  tied 0.
- LCD_EN  out  1  LCD enable strobe.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `rst` is synchronous and active high.
- Reset values:
  - LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
  - ack=0, gnt=0, ready=0, busy=1.
  - state=PWR, RR pointer=NREQ-1 (so requester 0 wins first), init index=0.
- Reset mid-operation: at the reset edge LCD_EN drops and the state returns to PWR. Any in-flight write is abandoned with no ack. The full power-up and init sequence repeats.
- States: PWR, IDLE, SETUP, PULSE, HOLD, WAIT, ACK.
- PWR: count T_PWR cycles, then load init entry 0 and go to SETUP.
- Init sequence: RS=0 throughout, bytes 0x38, 0x0C, 0x06, 0x01 in that order.
  - Init writes drive no gnt and no ack.
  - After the WAIT of entry 3 the block goes to IDLE and ready=1; ready stays 1 until reset.
- IDLE:
  - If any req bit is set, pick the first set index scanning from pointer+1 upward, modulo NREQ.
  - Latch that requester's req_rs and req_data into LCD_RS/LCD_DATA, set gnt for it, move the pointer to it, go to SETUP.
  - Latching happens on the IDLE-exit edge; later input changes have no effect.
  - If no req bit is set, stay in IDLE.
- SETUP: T_SU cycles with EN=0. Go to PULSE.
- PULSE: T_EN cycles with EN=1. Go to HOLD.
- HOLD: T_HLD cycles with EN=0 and DATA/RS unchanged. Go to WAIT.
- WAIT:
  - Wait T_CLR cycles if RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise wait T_CMD cycles.
  - Exit to ACK for a requester write, or to the next init entry (or IDLE after entry 3) during init.
- ACK: one cycle; ack[i]=1 and gnt cleared. Go to IDLE.
- Latency: requester write from IDLE-exit edge to ack high = T_SU+T_EN+T_HLD+Twait cycles; ack is high for exactly 1 cycle.
- Requester protocol:
  - A requester holds req with stable rs/data until it sees ack.
  - req still high in the cycle after ack counts as a new request with the data present then.
  - A req dropped before grant is simply not served.
- Requests during PWR/init are ignored until IDLE; they are not lost as long as req stays high.
- Timing counters:
  - Width is $clog2(max(T_PWR, T_CLR) + 1).
  - Each counter is loaded on state entry and exits when it reaches count-1.
  - A parameter value of 0 is treated as 1.
- Only one write is in flight at a time; gnt is at most one-hot.

Test Plan (overrides: T_SU=1, T_EN=2, T_HLD=1, T_CMD=4, T_CLR=8, T_PWR=10, NREQ=2):
- Reset release, no req -> after 10 cycles the init bytes 0x38, 0x0C, 0x06 appear on LCD_DATA with RS=0.
  - Each of these has EN high exactly 2 cycles and a write spacing of 8 cycles.
  - 0x01 follows with a 12-cycle span; ready rises on IDLE entry; no ack or gnt seen.
- After ready, req[0]=1, rs=1, data=0x41 -> LCD_DATA=0x41, RS=1, EN high 2 cycles; ack[0] pulses 8 cycles after the grant edge; busy low afterwards.
- Both req held high with data 0x30 (req0) and 0x31 (req1) -> writes alternate 0x30, 0x31, 0x30, ...; gnt never has 2 bits set.
- req[1] command 0x01 -> WAIT lasts 8 cycles and ack[1] arrives 12 cycles after the grant.
  - A following 0x80 command waits only 4 cycles.
- req_data changed in the SETUP cycle -> LCD_DATA keeps the latched value through HOLD.
- rst asserted during PULSE of a requester write -> next edge LCD_EN=0, gnt=0, ready=0, no ack; init resequences from 0x38.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// 16x2 character LCD write-port owner: power-up wait, fixed init sequence, then
// round-robin sharing of the port between NREQ requesters with full bus timing.
module lcd_write_arbiter #(
    parameter int NREQ  = 2,
    parameter int T_SU  = 4,
    parameter int T_EN  = 16,
    parameter int T_HLD = 4,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000,
    parameter int T_PWR = 750000
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_rs,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     gnt,
    output logic                ready,
    output logic                busy,
    output logic [7:0]          LCD_DATA,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic                LCD_EN
);

    // Zero-valued timing parameters behave as a single cycle.
    localparam int SU  = (T_SU  == 0) ? 1 : T_SU;
    localparam int EN  = (T_EN  == 0) ? 1 : T_EN;
    localparam int HLD = (T_HLD == 0) ? 1 : T_HLD;
    localparam int CMD = (T_CMD == 0) ? 1 : T_CMD;
    localparam int CLR = (T_CLR == 0) ? 1 : T_CLR;
    localparam int PWR = (T_PWR == 0) ? 1 : T_PWR;

    localparam int MAX_A = (PWR > CLR) ? PWR : CLR;
    localparam int MAX_B = (CMD > EN) ? CMD : EN;
    localparam int MAX_C = (SU > HLD) ? SU : HLD;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMAX  = (MAX_D > MAX_C) ? MAX_D : MAX_C;
    localparam int CW    = $clog2(TMAX + 1);
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] SU_M1  = CW'(SU - 1);
    localparam logic [CW-1:0] EN_M1  = CW'(EN - 1);
    localparam logic [CW-1:0] HLD_M1 = CW'(HLD - 1);
    localparam logic [CW-1:0] CMD_M1 = CW'(CMD - 1);
    localparam logic [CW-1:0] CLR_M1 = CW'(CLR - 1);
    localparam logic [CW-1:0] PWR_M1 = CW'(PWR - 1);

    typedef enum logic [2:0] {
        S_PWR, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            ready_q, ready_d;

    logic            found;
    logic [PW-1:0]   pick;
    logic            is_clear;
    logic [CW-1:0]   wait_m1;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Clear and home commands need the long execution wait.
    assign is_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    assign wait_m1  = is_clear ? CLR_M1 : CMD_M1;

    // Round-robin pick: first set request after the last winner.
    always_comb begin
        logic [PW-1:0] cand;
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_PWR;
            cnt_q      <= '0;
            ptr_q      <= PW'(NREQ - 1);
            sel_q      <= '0;
            init_idx_q <= 2'd0;
            data_q     <= 8'h00;
            rs_q       <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            init_idx_q <= init_idx_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        init_idx_d = init_idx_q;
        data_d     = data_q;
        rs_d       = rs_q;
        ready_d    = ready_q;
        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_M1) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    init_idx_d = 2'd0;
                    data_d     = init_byte(2'd0);
                    rs_d       = 1'b0;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d = S_SETUP;
                    sel_d   = pick;
                    ptr_d   = pick;
                    data_d  = req_data[{pick, 3'b000} +: 8];
                    rs_d    = req_rs[pick];
                end
            end
            S_SETUP: begin
                if (cnt_q == SU_M1) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                end
            end
            S_PULSE: begin
                if (cnt_q == EN_M1) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HLD_M1) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_m1) begin
                    cnt_d = '0;
                    if (ready_q) begin
                        state_d = S_ACK;
                    end else if (init_idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d    = S_SETUP;
                        init_idx_d = init_idx_q + 2'd1;
                        data_d     = init_byte(init_idx_q + 2'd1);
                        rs_d       = 1'b0;
                    end
                end
            end
            S_ACK: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_PWR;
            end
        endcase
    end

    // Init writes run with ready low, so they never raise gnt or ack.
    always_comb begin
        gnt    = '0;
        ack    = '0;
        LCD_EN = (state_q == S_PULSE);
        busy   = (state_q != S_IDLE);
        if (ready_q && (state_q == S_SETUP || state_q == S_PULSE ||
                        state_q == S_HOLD  || state_q == S_WAIT))
            gnt[sel_q] = 1'b1;
        if (state_q == S_ACK)
            ack[sel_q] = 1'b1;
    end

    assign ready    = ready_q;
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter: stimulus pushes predicted LCD writes,
// a negedge monitor pops and checks bus content, timing, gnt and ack.
module tb_lcd_write_arbiter;

    localparam int NREQ  = 2;
    localparam int T_SU  = 1;
    localparam int T_EN  = 2;
    localparam int T_HLD = 1;
    localparam int T_CMD = 4;
    localparam int T_CLR = 8;
    localparam int T_PWR = 10;

    logic              clock = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rs;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   gnt;
    logic              ready;
    logic              busy;
    logic [7:0]        LCD_DATA;
    logic              LCD_RS;
    logic              LCD_RW;
    logic              LCD_EN;

    lcd_write_arbiter #(
        .NREQ(NREQ), .T_SU(T_SU), .T_EN(T_EN), .T_HLD(T_HLD),
        .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)
    ) dut (
        .clock(clock), .rst(rst), .req(req), .req_rs(req_rs), .req_data(req_data),
        .ack(ack), .gnt(gnt), .ready(ready), .busy(busy),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         init;
        int         idx;
        logic [7:0] data;
        bit         rs;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  mp;

    logic [7:0] wd  [NREQ][4];
    bit         wrs [NREQ][4];
    int         nw  [NREQ];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int tw(input bit rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_CMD;
    endfunction

    task automatic push_init();
        logic [7:0] seq [4];
        seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 0, seq[i], 1'b0});
    endtask

    // Reference order: requesters hold req until their last ack, so the
    // served sequence is plain round-robin over the remaining write counts.
    task automatic model_push();
        int rem [NREQ];
        int used [NREQ];
        int tot;
        tot = 0;
        for (int i = 0; i < NREQ; i++) begin rem[i] = nw[i]; used[i] = 0; tot += nw[i]; end
        while (tot > 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (mp + k) % NREQ;
                if (rem[j] > 0) begin
                    exp_q.push_back('{1'b0, j, wd[j][used[j]], wrs[j][used[j]]});
                    rem[j]--; used[j]++; tot--; mp = j;
                    break;
                end
            end
        end
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!ready && n < bound) begin @(posedge clock); #1; n++; end
        chk("ready_reached", int'(ready), 1);
    endtask

    task automatic run_round(input bit perturb);
        int served [NREQ];
        logic [NREQ-1:0] gprev;
        int cyc;
        bit pending;
        model_push();
        for (int i = 0; i < NREQ; i++) begin
            served[i] = 0;
            if (nw[i] > 0) begin
                req[i] = 1'b1;
                req_rs[i] = wrs[i][0];
                req_data[8*i +: 8] = wd[i][0];
            end
        end
        gprev = '0;
        cyc = 0;
        pending = |req;
        while (pending && cyc < 400) begin
            @(posedge clock); #1; cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    served[i]++;
                    if (served[i] >= nw[i]) req[i] = 1'b0;
                    else begin
                        req_rs[i] = wrs[i][served[i]];
                        req_data[8*i +: 8] = wd[i][served[i]];
                    end
                end else if (perturb && gnt[i] && !gprev[i] && $urandom_range(0, 1) == 1) begin
                    req_data[8*i +: 8] = ~req_data[8*i +: 8];
                    req_rs[i] = ~req_rs[i];
                end
            end
            gprev = gnt;
            pending = |req;
        end
        chk("round_done_in_budget", int'(pending), 0);
        req = '0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic rand_round();
        int mask;
        mask = $urandom_range(1, (1 << NREQ) - 1);
        for (int i = 0; i < NREQ; i++) begin
            nw[i] = mask[i] ? $urandom_range(1, 3) : 0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wd[i][k] = 8'($urandom_range(1, 3));
                    wrs[i][k] = 1'b0;
                end else begin
                    wd[i][k] = 8'($urandom_range(0, 255));
                    wrs[i][k] = 1'($urandom_range(0, 1));
                end
            end
        end
        run_round(1'b1);
    endtask

    // Monitor state
    wr_t cur;
    bit  have_cur;
    int  since_en, since_rst, g_since, en_w;
    logic en_prev, ready_prev;
    logic [NREQ-1:0] ack_prev, gnt_prev;

    always @(negedge clock) begin
        if (rst) begin
            exp_q.delete();
            have_cur = 0; since_rst = 0; since_en = 0; g_since = 0; en_w = 0;
            en_prev = 0; ready_prev = 0; ack_prev = '0; gnt_prev = '0;
        end else begin
            since_rst++; since_en++; g_since++;
            chk("gnt_at_most_one_hot", int'($countones(gnt) <= 1), 1);
            chk("rw_low", int'(LCD_RW), 0);
            if (!ready) chk("no_gnt_ack_during_init", int'(gnt == '0 && ack == '0), 1);
            if (gnt != '0 && gnt_prev == '0) g_since = 0;

            if (LCD_EN && !en_prev) begin
                chk("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    wr_t nxt;
                    nxt = exp_q.pop_front();
                    if (have_cur && cur.init && nxt.init)
                        chk("init_write_spacing", since_en, T_SU + T_EN + T_HLD + tw(cur.rs, cur.data));
                    if (nxt.init && nxt.data == 8'h38)
                        chk("pwr_to_first_en", since_rst, T_PWR + T_SU + 1);
                    cur = nxt;
                    have_cur = 1;
                    since_en = 0;
                    chk("en_rise_gnt", int'(gnt), nxt.init ? 0 : (1 << nxt.idx));
                end
                en_w = 1;
            end else if (LCD_EN) begin
                en_w++;
            end
            if (!LCD_EN && en_prev) chk("en_high_width", en_w, T_EN);

            if (have_cur && since_en < T_EN + T_HLD) begin
                chk("lcd_data_stable", int'(LCD_DATA), int'(cur.data));
                chk("lcd_rs_stable", int'(LCD_RS), int'(cur.rs));
            end

            if (ack != '0) begin
                chk("ack_has_write", int'(have_cur && !cur.init), 1);
                chk("ack_single_cycle", int'(ack_prev), 0);
                if (have_cur && !cur.init) begin
                    chk("ack_index", int'(ack), 1 << cur.idx);
                    chk("en_to_ack", since_en, T_EN + T_HLD + tw(cur.rs, cur.data));
                    chk("grant_to_ack", g_since, T_SU + T_EN + T_HLD + tw(cur.rs, cur.data));
                end
                have_cur = 0;
            end
            if (ack_prev != '0) chk("idle_after_ack", int'(busy), 0);

            if (ready && !ready_prev) begin
                chk("ready_after_clear", int'(have_cur && cur.init && cur.data == 8'h01), 1);
                chk("last_init_to_ready", since_en, T_EN + T_HLD + T_CLR);
                have_cur = 0;
            end

            en_prev = LCD_EN; ready_prev = ready; ack_prev = ack; gnt_prev = gnt;
        end
    end

    initial begin
        int n;
        rst = 1'b1; req = '0; req_rs = '0; req_data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_en", int'(LCD_EN), 0);
        chk("reset_data", int'(LCD_DATA), 0);
        chk("reset_rs", int'(LCD_RS), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_gnt_ack", int'({gnt, ack}), 0);
        rst = 1'b0;
        mp = NREQ - 1;
        push_init();
        wait_ready(200);

        // Single data write from requester 0.
        foreach (nw[i]) nw[i] = 0;
        nw[0] = 1; wd[0][0] = 8'h41; wrs[0][0] = 1'b1;
        run_round(1'b0);

        // Both held: writes must alternate.
        nw[0] = 3; nw[1] = 3;
        for (int k = 0; k < 3; k++) begin
            wd[0][k] = 8'h30; wrs[0][k] = 1'b1;
            wd[1][k] = 8'h31; wrs[1][k] = 1'b1;
        end
        run_round(1'b0);

        // Clear command (long wait) then a normal command, with input churn.
        nw[0] = 0; nw[1] = 2;
        wd[1][0] = 8'h01; wrs[1][0] = 1'b0;
        wd[1][1] = 8'h80; wrs[1][1] = 1'b0;
        run_round(1'b1);

        repeat (12) rand_round();

        // Reset in the middle of a requester write's enable pulse.
        foreach (nw[i]) nw[i] = 0;
        nw[0] = 1; wd[0][0] = 8'h55; wrs[0][0] = 1'b1;
        model_push();
        req[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h55;
        n = 0;
        while (!LCD_EN && n < 50) begin @(posedge clock); #1; n++; end
        chk("pulse_reached", int'(LCD_EN), 1);
        rst = 1'b1; req = '0;
        @(posedge clock); #1;
        chk("midop_reset_en", int'(LCD_EN), 0);
        chk("midop_reset_gnt", int'(gnt), 0);
        chk("midop_reset_ack", int'(ack), 0);
        chk("midop_reset_ready", int'(ready), 0);
        chk("midop_reset_busy", int'(busy), 1);
        rst = 1'b0;
        mp = NREQ - 1;
        push_init();
        wait_ready(200);

        repeat (3) rand_round();
        repeat (4) @(posedge clock);
        #1;
        chk("expected_writes_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
